hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter LOAD_USE_CYCLES, default 1, stall cycles per load-use hazard; legal range 1..3.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port ex_valid, input, 1, EX-stage instruction valid (ID/EX valid output).
REQ-006 SHALL have port ex_mem_read, input, 1, EX instruction is a load.
REQ-007 SHALL have port ex_wb_en, input, 1, EX instruction writes the register file.
REQ-008 SHALL have port ex_dest, input, 3, EX destination register index.
REQ-009 SHALL have port ex_branch_taken, input, 1, EX resolved a taken branch or jump.
REQ-010 SHALL have port id_valid, input, 1, ID-stage instruction valid.
REQ-011 SHALL have ports id_src1 and id_src2, input, 4 each; bit 3 is the operand-used flag, bits 2:0 the register index.
REQ-012 SHALL have port pc_write, output, 1, PC update enable.
REQ-013 SHALL have port if_id_write, output, 1, IF/ID register load enable.
REQ-014 SHALL have port id_ex_bubble, output, 1, forces ID/EX valid input and control fields to 0.
REQ-015 SHALL have port if_id_flush, output, 1, clears IF/ID valid.
REQ-016 SHALL have port stall_active, output, 1, high in any cycle in which pc_write is 0.
REQ-017 SHALL have port stall_count, output, CNT_W, cumulative stall cycles; present only per REQ-036.

Function
REQ-018 SHALL implement an FSM with states RUN and STALL; state is registered, and outputs are combinational from state and current inputs.
REQ-019 SHALL define hazard = ex_valid & ex_mem_read & ex_wb_en & id_valid & ((id_src1[3] & id_src1[2:0]==ex_dest) | (id_src2[3] & id_src2[2:0]==ex_dest)).
REQ-020 SHALL define flush = ex_valid & ex_branch_taken.
REQ-021 Default, in RUN with no hazard and no flush: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
REQ-022 In RUN with hazard and no flush: pc_write=0, if_id_write=0, id_ex_bubble=1, in the same cycle.
REQ-023 On hazard in RUN with LOAD_USE_CYCLES=1, the FSM SHALL stay in RUN, giving exactly one stall cycle.
REQ-024 On hazard in RUN with LOAD_USE_CYCLES>1, the FSM SHALL enter STALL with a remaining-cycle counter loaded to LOAD_USE_CYCLES-1.
REQ-025 In STALL, outputs SHALL equal those of REQ-022 regardless of the hazard term; the counter decrements each cycle, and the FSM returns to RUN in the cycle after the counter reads 1.
REQ-026 Flush SHALL have priority in any state: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; the next state is RUN and the counter is cleared.
REQ-027 When hazard and flush occur in the same cycle, flush SHALL win and no stall cycle is produced.
REQ-028 Each hazard occurrence SHALL yield exactly LOAD_USE_CYCLES consecutive cycles with pc_write=0 unless aborted by flush.
REQ-029 An operand with flag bit 3 = 0 SHALL never cause a hazard, even when its index matches ex_dest.

Reset
REQ-030 While reset is high at a clock edge, the next state SHALL be RUN, the remaining-cycle counter 0 and stall_count 0.
REQ-031 Reset SHALL abort a STALL in progress; in the first cycle after reset, outputs follow REQ-021 or REQ-022 from current inputs.
REQ-032 Outputs during the reset cycle SHALL be pc_write=1, if_id_write=1, id_ex_bubble=1, if_id_flush=1, so no wrong-path state propagates.

Configuration
REQ-033 Macro HAZ_STALL_CNT_EN SHALL control the performance counter.
REQ-034 With HAZ_STALL_CNT_EN defined, stall_count SHALL increment by 1 on each clock edge where stall_active=1 and reset=0.
REQ-035 With HAZ_STALL_CNT_EN defined, stall_count SHALL saturate at 2^CNT_W-1.
REQ-036 Without HAZ_STALL_CNT_EN, port stall_count and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-037 LOAD_USE_CYCLES=1; EX load with ex_dest=3 and ex_wb_en=1; ID id_src1=4'b1011 -> one cycle pc_write=0, id_ex_bubble=1, then normal.
REQ-038 LOAD_USE_CYCLES=3; same stimulus -> three consecutive stall cycles, then RUN; stall_count advances 0 to 3.
REQ-039 Hazard stimulus plus ex_branch_taken=1 in the same cycle -> if_id_flush=1, pc_write=1, no stall; stall_count unchanged.
REQ-040 LOAD_USE_CYCLES=3; reset asserted in the 2nd stall cycle -> the next cycle is RUN, stall_count=0, and the pipeline advances.
REQ-041 id_src2=4'b0011 (unused operand) with an EX load to r3 -> no stall; id_src2=4'b1011 -> one stall cycle.
REQ-042 CNT_W=4 with HAZ_STALL_CNT_EN defined; 20 stall cycles -> stall_count holds 15.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall / branch flush controller for a 5-stage pipeline.
// Optional macro HAZ_STALL_CNT_EN adds a saturating stall-cycle counter on port stall_count.
module hazard_ctrl_unit #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic       ex_wb_en,
  input  logic [2:0] ex_dest,
  input  logic       ex_branch_taken,
  input  logic       id_valid,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic       stall_active
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] RELOAD = 2'(LOAD_USE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] remCnt_q, remCnt_d;
  logic       src1Hit, src2Hit, hazard, flush;

  // An operand only matters when its used-flag (bit 3) is set.
  assign src1Hit = id_src1[3] & (id_src1[2:0] == ex_dest);
  assign src2Hit = id_src2[3] & (id_src2[2:0] == ex_dest);
  assign hazard  = ex_valid & ex_mem_read & ex_wb_en & id_valid & (src1Hit | src2Hit);
  assign flush   = ex_valid & ex_branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      remCnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      remCnt_q <= remCnt_d;
    end
  end

  // Priority: reset, then flush, then an ongoing stall, then a fresh hazard.
  always_comb begin
    state_d      = state_q;
    remCnt_d     = remCnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (reset) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      state_d      = RUN;
      remCnt_d     = 2'd0;
    end else if (flush) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      state_d      = RUN;
      remCnt_d     = 2'd0;
    end else if (state_q == STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (remCnt_q <= 2'd1) begin
        state_d  = RUN;
        remCnt_d = 2'd0;
      end else begin
        remCnt_d = remCnt_q - 2'd1;
      end
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        state_d  = STALL;
        remCnt_d = RELOAD;
      end
    end
  end

  assign stall_active = ~pc_write;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stallCount_q;

  // Saturates rather than wrapping so long runs never under-report.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount_q <= '0;
    end else if (stall_active && (stallCount_q != '1)) begin
      stallCount_q <= stallCount_q + CNT_W'(1);
    end
  end

  assign stall_count = stallCount_q;
`else
  // CNT_W only sizes the optional counter; an illegal width still elaborates a marker block.
  if (CNT_W < 1) begin : gBadCntW
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench: one instance with LOAD_USE_CYCLES=1, one with 3, sharing stimulus.
module tb_hazard_ctrl_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ex_valid = 1'b0, ex_mem_read = 1'b0, ex_wb_en = 1'b0, ex_branch_taken = 1'b0;
  logic [2:0] ex_dest = 3'd0;
  logic       id_valid = 1'b0;
  logic [3:0] id_src1 = 4'd0, id_src2 = 4'd0;

  logic pcW1, ifIdW1, bub1, fl1, sa1;
  logic pcW3, ifIdW3, bub3, fl3, sa3;

  int total = 0;
  int bad   = 0;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active}
  localparam logic [4:0] RUN_O   = 5'b11000;
  localparam logic [4:0] STALL_O = 5'b00101;
  localparam logic [4:0] FLUSH_O = 5'b11110;
  localparam logic [4:0] RST_O   = 5'b11110;

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] cnt1, cnt3;
  logic [3:0]  cnt4;
  logic pcW4, ifIdW4, bub4, fl4, sa4;
`endif

  always #5 clock = ~clock;

  hazard_ctrl_unit #(.LOAD_USE_CYCLES(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .pc_write(pcW1), .if_id_write(ifIdW1), .id_ex_bubble(bub1), .if_id_flush(fl1),
    .stall_active(sa1)
`ifdef HAZ_STALL_CNT_EN
    , .stall_count(cnt1)
`endif
  );

  hazard_ctrl_unit #(.LOAD_USE_CYCLES(3), .CNT_W(16)) dut3 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .pc_write(pcW3), .if_id_write(ifIdW3), .id_ex_bubble(bub3), .if_id_flush(fl3),
    .stall_active(sa3)
`ifdef HAZ_STALL_CNT_EN
    , .stall_count(cnt3)
`endif
  );

`ifdef HAZ_STALL_CNT_EN
  hazard_ctrl_unit #(.LOAD_USE_CYCLES(1), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .pc_write(pcW4), .if_id_write(ifIdW4), .id_ex_bubble(bub4), .if_id_flush(fl4),
    .stall_active(sa4), .stall_count(cnt4)
  );
`endif

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic rd, input logic wb,
                               input logic [2:0] dest, input logic br, input logic idv,
                               input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clock);
    reset = rst; ex_valid = vld; ex_mem_read = rd; ex_wb_en = wb; ex_dest = dest;
    ex_branch_taken = br; id_valid = idv; id_src1 = s1; id_src2 = s2;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [4:0] exp1, input logic [4:0] exp3);
    checkOutput({tag, "/L1"}, {11'd0, pcW1, ifIdW1, bub1, fl1, sa1}, {11'd0, exp1});
    checkOutput({tag, "/L3"}, {11'd0, pcW3, ifIdW3, bub3, fl3, sa3}, {11'd0, exp3});
  endtask

  initial begin
    // rst vld rd wb dest br idv s1 s2
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 0, 4'h0, 4'h0); checkBoth("resetCycle", RST_O, RST_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 0, 4'h0, 4'h0); checkBoth("idleAfterReset", RUN_O, RUN_O);
`ifdef HAZ_STALL_CNT_EN
    checkOutput("cntAfterReset", cnt3, 16'd0);
`endif
    // Load to r3 with ID reading r3 on src1.
    applyStimulus(0, 1, 1, 1, 3'd3, 0, 1, 4'b1011, 4'h0); checkBoth("hazardSrc1", STALL_O, STALL_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("stall2", RUN_O, STALL_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("stall3", RUN_O, STALL_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("backToRun", RUN_O, RUN_O);
`ifdef HAZ_STALL_CNT_EN
    checkOutput("cntL3After3", cnt3, 16'd3);
    checkOutput("cntL1After1", cnt1, 16'd1);
`endif
    // Hazard and taken branch together: flush wins, no stall.
    applyStimulus(0, 1, 1, 1, 3'd3, 1, 1, 4'b1011, 4'h0); checkBoth("hazardPlusFlush", FLUSH_O, FLUSH_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("afterFlush", RUN_O, RUN_O);
`ifdef HAZ_STALL_CNT_EN
    checkOutput("cntUnchangedFlush", cnt3, 16'd3);
`endif
    // Flush arriving while L3 is mid-stall aborts the stall.
    applyStimulus(0, 1, 1, 1, 3'd3, 0, 1, 4'b1011, 4'h0); checkBoth("hazardAgain", STALL_O, STALL_O);
    applyStimulus(0, 1, 0, 0, 3'd5, 1, 1, 4'h0, 4'h0);    checkBoth("flushInStall", FLUSH_O, FLUSH_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("afterStallFlush", RUN_O, RUN_O);
    // Reset during the second stall cycle.
    applyStimulus(0, 1, 1, 1, 3'd3, 0, 1, 4'b1011, 4'h0); checkBoth("hazardPreReset", STALL_O, STALL_O);
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("resetInStall", RST_O, RST_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("runAfterReset", RUN_O, RUN_O);
`ifdef HAZ_STALL_CNT_EN
    checkOutput("cntClearedByReset", cnt3, 16'd0);
`endif
    // Unused operand matching ex_dest must not stall; used one on src2 must.
    applyStimulus(0, 1, 1, 1, 3'd3, 0, 1, 4'h0, 4'b0011); checkBoth("src2Unused", RUN_O, RUN_O);
    applyStimulus(0, 1, 1, 1, 3'd3, 0, 1, 4'h0, 4'b1011); checkBoth("src2Used", STALL_O, STALL_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("src2Stall2", RUN_O, STALL_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("src2Stall3", RUN_O, STALL_O);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 1, 4'h0, 4'h0);    checkBoth("src2Done", RUN_O, RUN_O);
    // Each missing hazard qualifier suppresses the stall.
    applyStimulus(0, 1, 1, 0, 3'd3, 0, 1, 4'b1011, 4'h0); checkBoth("noWbEn", RUN_O, RUN_O);
    applyStimulus(0, 1, 1, 1, 3'd3, 0, 0, 4'b1011, 4'h0); checkBoth("idInvalid", RUN_O, RUN_O);
    applyStimulus(0, 1, 1, 1, 3'd3, 0, 1, 4'b1010, 4'b1100); checkBoth("destMismatch", RUN_O, RUN_O);
    applyStimulus(0, 1, 0, 1, 3'd3, 0, 1, 4'b1011, 4'h0); checkBoth("notLoad", RUN_O, RUN_O);
    applyStimulus(0, 0, 1, 1, 3'd3, 1, 1, 4'b1011, 4'h0); checkBoth("exInvalid", RUN_O, RUN_O);
`ifdef HAZ_STALL_CNT_EN
    // Twenty back-to-back stall cycles: 4-bit counter saturates at 15.
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1, 1, 3'd3, 0, 1, 4'b1011, 4'h0);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 0, 4'h0, 4'h0);
    checkOutput("cntSaturate4b", {12'd0, cnt4}, 16'd15);
    checkOutput("cnt16bAfter20", cnt3, 16'd20);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
